// File: rtl/tone_sequencer_if.sv
// tone_sequencer_if: song ROM port and tone generator drive bundle of one sequencer channel
interface tone_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] start_addr;
    logic              loop;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [5:0]        tone;
    logic [3:0]        vol;
    logic              busy;
    logic              note_stb;
    logic              done;

    modport master (
        input  start, stop, start_addr, loop, rom_data,
        output rom_addr, tone, vol, busy, note_stb, done
    );

    modport slave (
        output start, stop, start_addr, loop, rom_data,
        input  rom_addr, tone, vol, busy, note_stb, done
    );
endinterface

// File: rtl/tone_sequencer.sv
// tone_sequencer: walks a song table in ROM and drives TONE/VOL note by note; NOTE_GAP_EN adds a silent gap after each note
module tone_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int BEAT_DIV   = 6250000,
    parameter int GAP_CYCLES = 1000000,
    parameter int TONE_MAX   = 48
) (
    input  logic clk_i,
    input  logic rst_n_i,
    tone_sequencer_if.master bus
);
    localparam int PRE_W = BEAT_DIV > 1 ? $clog2(BEAT_DIV) : 1;

    if (BEAT_DIV < 1 || GAP_CYCLES < 1) begin : g_bad_param
        $error("BEAT_DIV and GAP_CYCLES must be at least 1");
    end

`ifdef NOTE_GAP_EN
    localparam int GAP_W = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;
    logic [GAP_W-1:0] gap_q, gap_d;
`else
    typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, base_q, base_d;
    logic [5:0]        tone_q, tone_d, dur_q, dur_d;
    logic [3:0]        vol_q, vol_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              stb_q, stb_d, done_q, done_d;

    assign bus.rom_addr = addr_q;
    assign bus.tone     = tone_q;
    assign bus.vol      = vol_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.note_stb = stb_q;
    assign bus.done     = done_q;

    // Register all state and outputs; reset silences the channel and parks at address 0
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            base_q  <= '0;
            tone_q  <= '0;
            vol_q   <= '0;
            dur_q   <= '0;
            pre_q   <= '0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef NOTE_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            tone_q  <= tone_d;
            vol_q   <= vol_d;
            dur_q   <= dur_d;
            pre_q   <= pre_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
`ifdef NOTE_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    // Next state: STOP overrides everything; otherwise fetch, decode and time each table entry
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        base_d  = base_q;
        tone_d  = tone_q;
        vol_d   = vol_q;
        dur_d   = dur_q;
        pre_d   = pre_q;
        stb_d   = 1'b0;
        done_d  = 1'b0;
`ifdef NOTE_GAP_EN
        gap_d   = gap_q;
`endif
        if (bus.stop) begin
            state_d = IDLE;
            tone_d  = '0;
            vol_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    base_d  = bus.start_addr;
                    addr_d  = bus.start_addr;
                    state_d = FETCH;
                end
                FETCH: state_d = LOAD;
                LOAD: if (bus.rom_data[5:0] == 6'd0) begin
                    // End marker: looping leaves the current outputs untouched
                    if (bus.loop) begin
                        addr_d  = base_q;
                        state_d = FETCH;
                    end else begin
                        tone_d  = '0;
                        vol_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    tone_d  = (int'(bus.rom_data[15:10]) > TONE_MAX) ? 6'd0 : bus.rom_data[15:10];
                    vol_d   = bus.rom_data[9:6];
                    dur_d   = bus.rom_data[5:0];
                    pre_d   = '0;
                    stb_d   = 1'b1;
                    state_d = PLAY;
                end
                PLAY: if (pre_q == PRE_W'(BEAT_DIV - 1)) begin
                    pre_d = '0;
                    dur_d = dur_q - 1'b1;
                    if (dur_q == 6'd1) begin
                        addr_d = addr_q + 1'b1;
`ifdef NOTE_GAP_EN
                        vol_d   = '0;
                        gap_d   = '0;
                        state_d = GAP;
`else
                        state_d = FETCH;
`endif
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
`ifdef NOTE_GAP_EN
                GAP: if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = FETCH;
                     else gap_d = gap_q + 1'b1;
`endif
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: scoreboard bench for tone_sequencer with BEAT_DIV=4, GAP_CYCLES=2, ADDR_W=4; NOTE_GAP_EN selects gap build
module tb_tone_sequencer;
    localparam int G = `ifdef NOTE_GAP_EN 2 `else 0 `endif;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_n = 0;
    int done_cyc = 0;
    int rd = 0;
    logic [9:0] last_tv = '0;
    logic [9:0] pre_done = '0;
    logic [15:0] rom [16];
    logic [13:0] exp_q [$];
    logic [13:0] obs_q [$];
    int stb_cyc [$];

    tone_sequencer_if #(.ADDR_W(4)) bus ();

    tone_sequencer #(.ADDR_W(4), .BEAT_DIV(4), .GAP_CYCLES(2), .TONE_MAX(48)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.note_stb) begin
            obs_q.push_back({bus.tone, bus.vol, bus.rom_addr});
            stb_cyc.push_back(cyc);
        end
        if (bus.done) begin
            done_n = done_n + 1;
            done_cyc = cyc;
            pre_done = last_tv;
        end
        last_tv = {bus.tone, bus.vol};
    end

    function automatic logic [15:0] ent(int t, int v, int d);
        return {t[5:0], v[3:0], d[5:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 16'h0;
    endtask

    task automatic pulse_start(input logic [3:0] a);
        bus.start_addr = a;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while (bus.busy && k < max) begin
            tick();
            k++;
        end
        if (bus.busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", bus.busy, max);
        end
        #4;
    endtask

    task automatic wait_stb(input int n, input int max);
        int k = 0;
        while (obs_q.size() < n && k < max) begin
            tick();
            k++;
        end
        if (obs_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_stb: %0d strobes, required %0d", obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        checks += 6;
        if (bus.tone !== 6'd0) begin errors++; $display("FAIL rst_tone: got %0d required 0", bus.tone); end
        if (bus.vol !== 4'd0) begin errors++; $display("FAIL rst_vol: got %0d required 0", bus.vol); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        if (bus.rom_addr !== 4'd0) begin errors++; $display("FAIL rst_addr: got %0d required 0", bus.rom_addr); end
        if (bus.note_stb !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b required 0", bus.note_stb); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", bus.done); end
    endtask

    task automatic test_single();
        int d0 = done_n;
        int r0 = rd;
        logic [13:0] e;
        clear_rom();
        rom[0] = ent(10, 8, 2);
        bus.loop = 1'b0;
        exp_q.push_back({6'd10, 4'd8, 4'd0});
        pulse_start(4'd0);
        checks++;
        if (bus.busy !== 1'b1 || bus.rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL single_fetch: busy=%b addr=%0d required busy=1 addr=0", bus.busy, bus.rom_addr);
        end
        tick();
        tick();
        checks++;
        if ({bus.tone, bus.vol, bus.note_stb} !== {6'd10, 4'd8, 1'b1}) begin
            errors++;
            $display("FAIL single_latency: tone=%0d vol=%0d stb=%b required 10 8 1", bus.tone, bus.vol, bus.note_stb);
        end
        wait_idle(100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                errors++;
                $display("FAIL single_note: got %h required %h", (rd < obs_q.size()) ? obs_q[rd] : 14'h0, e);
            end
            rd++;
        end
        checks += 7;
        if (obs_q.size() !== r0 + 1) begin errors++; $display("FAIL single_stb_count: got %0d required %0d", obs_q.size() - r0, 1); end
        if (done_n - d0 !== 1) begin errors++; $display("FAIL single_done: got %0d pulses required 1", done_n - d0); end
        if (done_cyc - stb_cyc[r0] !== 10 + G) begin errors++; $display("FAIL single_dur: got %0d cycles required %0d", done_cyc - stb_cyc[r0], 10 + G); end
        if (pre_done !== {6'd10, (G == 0) ? 4'd8 : 4'd0}) begin errors++; $display("FAIL single_hold: got %h required %h", pre_done, {6'd10, (G == 0) ? 4'd8 : 4'd0}); end
        if (bus.tone !== 6'd0) begin errors++; $display("FAIL single_tone_end: got %0d required 0", bus.tone); end
        if (bus.vol !== 4'd0) begin errors++; $display("FAIL single_vol_end: got %0d required 0", bus.vol); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b required 0", bus.busy); end
    endtask

    task automatic test_loop();
        int d0 = done_n;
        int r0 = rd;
        logic [13:0] e;
        clear_rom();
        rom[0] = ent(5, 15, 1);
        rom[1] = ent(0, 15, 1);
        bus.loop = 1'b1;
        exp_q.push_back({6'd5, 4'd15, 4'd0});
        exp_q.push_back({6'd0, 4'd15, 4'd1});
        exp_q.push_back({6'd5, 4'd15, 4'd0});
        exp_q.push_back({6'd0, 4'd15, 4'd1});
        pulse_start(4'd0);
        wait_stb(r0 + 4, 200);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                errors++;
                $display("FAIL loop_note: got %h required %h", (rd < obs_q.size()) ? obs_q[rd] : 14'h0, e);
            end
            rd++;
        end
        checks += 3;
        if (stb_cyc[r0 + 1] - stb_cyc[r0] !== 6 + G) begin errors++; $display("FAIL loop_gap1: got %0d required %0d", stb_cyc[r0 + 1] - stb_cyc[r0], 6 + G); end
        if (stb_cyc[r0 + 2] - stb_cyc[r0 + 1] !== 8 + G) begin errors++; $display("FAIL loop_wrap: got %0d required %0d", stb_cyc[r0 + 2] - stb_cyc[r0 + 1], 8 + G); end
        if (stb_cyc[r0 + 3] - stb_cyc[r0 + 2] !== 6 + G) begin errors++; $display("FAIL loop_gap2: got %0d required %0d", stb_cyc[r0 + 3] - stb_cyc[r0 + 2], 6 + G); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        checks += 2;
        if ({bus.busy, bus.tone, bus.vol} !== 11'd0) begin errors++; $display("FAIL loop_stop: busy=%b tone=%0d vol=%0d required 0 0 0", bus.busy, bus.tone, bus.vol); end
        #4;
        if (done_n - d0 !== 0) begin errors++; $display("FAIL loop_no_done: got %0d pulses required 0", done_n - d0); end
        rd = obs_q.size();
    endtask

`ifdef NOTE_GAP_EN
    task automatic test_gap();
        int r0 = rd;
        logic [13:0] e;
        clear_rom();
        rom[0] = ent(10, 8, 1);
        rom[1] = ent(20, 8, 1);
        bus.loop = 1'b0;
        exp_q.push_back({6'd10, 4'd8, 4'd0});
        exp_q.push_back({6'd20, 4'd8, 4'd1});
        pulse_start(4'd0);
        wait_stb(r0 + 1, 50);
        tick();
        tick();
        tick();
        checks++;
        if ({bus.tone, bus.vol} !== {6'd10, 4'd0}) begin errors++; $display("FAIL gap_first: tone=%0d vol=%0d required 10 0", bus.tone, bus.vol); end
        tick();
        checks++;
        if ({bus.tone, bus.vol} !== {6'd10, 4'd0}) begin errors++; $display("FAIL gap_second: tone=%0d vol=%0d required 10 0", bus.tone, bus.vol); end
        wait_idle(100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                errors++;
                $display("FAIL gap_note: got %h required %h", (rd < obs_q.size()) ? obs_q[rd] : 14'h0, e);
            end
            rd++;
        end
        checks++;
        if (stb_cyc[r0 + 1] - stb_cyc[r0] !== 8) begin errors++; $display("FAIL gap_spacing: got %0d required 8", stb_cyc[r0 + 1] - stb_cyc[r0]); end
        rd = obs_q.size();
    endtask
`endif

    task automatic test_stop();
        int d0 = done_n;
        int n0;
        clear_rom();
        rom[0] = ent(7, 9, 3);
        bus.loop = 1'b0;
        pulse_start(4'd0);
        wait_stb(rd + 1, 50);
        tick();
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.tone, bus.vol} !== {1'b1, 6'd7, 4'd9}) begin errors++; $display("FAIL stop_playing: busy=%b tone=%0d vol=%0d required 1 7 9", bus.busy, bus.tone, bus.vol); end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        checks++;
        if ({bus.busy, bus.tone, bus.vol} !== 11'd0) begin errors++; $display("FAIL stop_mid: busy=%b tone=%0d vol=%0d required 0 0 0", bus.busy, bus.tone, bus.vol); end
        tick();
        tick();
        n0 = obs_q.size();
        bus.stop = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.stop = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL stop_beats_start: busy=%b required 0", bus.busy); end
        for (int i = 0; i < 6; i++) tick();
        #4;
        checks += 2;
        if (obs_q.size() !== n0 || bus.busy !== 1'b0) begin errors++; $display("FAIL stop_start_ignored: strobes=%0d busy=%b required %0d 0", obs_q.size(), bus.busy, n0); end
        if (done_n - d0 !== 0) begin errors++; $display("FAIL stop_no_done: got %0d pulses required 0", done_n - d0); end
        rd = obs_q.size();
    endtask

    task automatic test_wrap();
        int d0 = done_n;
        logic [13:0] e;
        clear_rom();
        rom[15] = ent(48, 4, 1);
        rom[0] = ent(49, 4, 1);
        bus.loop = 1'b0;
        exp_q.push_back({6'd48, 4'd4, 4'd15});
        exp_q.push_back({6'd0, 4'd4, 4'd0});
        pulse_start(4'd15);
        wait_idle(100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                errors++;
                $display("FAIL wrap_note: got %h required %h", (rd < obs_q.size()) ? obs_q[rd] : 14'h0, e);
            end
            rd++;
        end
        checks += 2;
        if (done_n - d0 !== 1) begin errors++; $display("FAIL wrap_done: got %0d pulses required 1", done_n - d0); end
        if ({bus.busy, bus.tone, bus.vol} !== 11'd0) begin errors++; $display("FAIL wrap_end: busy=%b tone=%0d vol=%0d required 0 0 0", bus.busy, bus.tone, bus.vol); end
        rd = obs_q.size();
    endtask

    task automatic test_back_to_back_reset();
        int d0 = done_n;
        logic [13:0] e;
        clear_rom();
        rom[2] = ent(12, 3, 2);
        bus.loop = 1'b0;
        exp_q.push_back({6'd12, 4'd3, 4'd2});
        exp_q.push_back({6'd12, 4'd3, 4'd2});
        pulse_start(4'd2);
        wait_stb(rd + 1, 50);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        test_reset();
        tick();
        pulse_start(4'd2);
        wait_idle(100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (rd >= obs_q.size() || obs_q[rd] !== e) begin
                errors++;
                $display("FAIL replay_note: got %h required %h", (rd < obs_q.size()) ? obs_q[rd] : 14'h0, e);
            end
            rd++;
        end
        checks++;
        if (done_n - d0 !== 1) begin errors++; $display("FAIL replay_done: got %0d pulses required 1", done_n - d0); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.loop = 1'b0;
        bus.start_addr = '0;
        clear_rom();
        tick();
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_single();
        tick();
        test_loop();
        tick();
`ifdef NOTE_GAP_EN
        test_gap();
        tick();
`endif
        test_stop();
        tick();
        test_wrap();
        tick();
        test_back_to_back_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Note sequencer that drives the TONE/VOL inputs of one tone generator channel from a song table held in a synchronous ROM. Each table entry gives a tone code, a volume and a duration in beats. The block walks the table, holds each note for its exact duration, and stops or loops at an end marker. It sits between the song ROM and the tone generator inside the AudioController.

## Interface
Parameters:
- ADDR_W, 8, song ROM address width.
- BEAT_DIV, 6250000, CLK cycles per duration unit (62.5 ms at 100 MHz); minimum 1.
- GAP_CYCLES, 1000000, silent articulation gap after each note; used only with NOTE_GAP_EN; minimum 1.
- TONE_MAX, 48, highest valid tone code.

Ports:
- CLK  in  1  100 MHz clock.
- RST_N  in  1  synchronous, active-low reset.
- START  in  1  single-cycle pulse; begins playback from START_ADDR when idle.
- STOP  in  1  aborts playback.
- START_ADDR  in  ADDR_W  first table entry; latched when START is accepted.
- LOOP  in  1  sampled at each end marker; 1 = restart from the latched start address.
- ROM_ADDR  out  ADDR_W  table address.
- ROM_DATA  in  16  entry: [15:10] tone, [9:6] vol, [5:0] dur. Valid in the cycle after the ROM registers ROM_ADDR.
- TONE  out  6  tone code to the generator.
- VOL  out  4  volume to the generator.
- BUSY  out  1  high in every state except IDLE.
- NOTE_STB  out  1  one-cycle pulse in the first PLAY cycle of each note.
- DONE  out  1  one-cycle pulse when playback ends at a non-looping end marker.

## Operation
States: IDLE, FETCH, LOAD, PLAY, GAP (GAP only with NOTE_GAP_EN).

- **Reset:** all outputs are 0, ROM_ADDR = 0, state = IDLE.
- **IDLE:**
  - START=1 and STOP=0: latch START_ADDR, drive ROM_ADDR = START_ADDR, go to FETCH.
  - START while BUSY is ignored.
- **FETCH:** hold ROM_ADDR for one cycle, then go to LOAD.
- **LOAD:** decode ROM_DATA.
  - dur = 0 is the end marker. Outputs are not changed on this edge.
    - LOOP=1: ROM_ADDR = latched start address, go to FETCH.
    - LOOP=0: TONE = 0, VOL = 0, pulse DONE, go to IDLE.
  - dur ≠ 0:
    - TONE = tone, or 0 if tone > TONE_MAX.
    - VOL = vol.
    - Load the duration counter with dur, clear the prescaler, go to PLAY.
    - Assert NOTE_STB on the next cycle.
- **PLAY:**
  - The prescaler counts 0..BEAT_DIV-1. Each time it wraps, the duration counter decrements.
  - When the duration counter would reach 0, ROM_ADDR increments (mod 2^ADDR_W) and the next state is GAP, or FETCH if GAP is compiled out.
- **GAP:** VOL = 0 and TONE is held for GAP_CYCLES cycles, then go to FETCH.
- **STOP:** STOP=1 in any state means next state IDLE, TONE = 0, VOL = 0, no DONE. STOP beats START in the same cycle.
- **Address wrap:** after ROM_ADDR = 2^ADDR_W-1, the table continues at 0 with no error.
- **Tone 0:** a legitimate rest; VOL is still driven as stored.
- **Empty loop:** an end marker at the start address with LOOP=1 cycles FETCH/LOAD indefinitely. BUSY stays high and outputs stay 0 until STOP.

## Timing
- START sampled at edge E0. First note TONE/VOL are valid after E2 (2-cycle latency). NOTE_STB is high during the cycle after E2.
- A note of duration d holds TONE/VOL for exactly d×BEAT_DIV cycles of PLAY.
- Between consecutive notes there are 2 cycles (FETCH, LOAD), plus GAP_CYCLES if enabled.
  - Without NOTE_GAP_EN, the previous TONE/VOL are held through those 2 cycles, so there is no silence glitch.
  - With NOTE_GAP_EN, VOL is 0 during the GAP cycles.
- All outputs are registered. No combinational path from inputs to outputs.
- Counter widths:
  - prescaler is ceil(log2(BEAT_DIV)) bits, minimum 1;
  - duration counter is 6 bits;
  - gap counter is ceil(log2(GAP_CYCLES)) bits, minimum 1.

## Configuration
- **NOTE_GAP_EN defined:** the GAP state is present. VOL = 0 for GAP_CYCLES after every note, including before an end marker is fetched.
- **NOTE_GAP_EN undefined:** no GAP state and no gap counter. PLAY goes directly to FETCH and notes are legato.

## Test plan
Run with BEAT_DIV=4, GAP_CYCLES=2, ADDR_W=4.

1. ROM[0]={10,8,2}, ROM[1]=end; START, START_ADDR=0, LOOP=0 → TONE=10, VOL=8 after 2 cycles, held 8 PLAY cycles, then (gap off) 2 cycles held, then DONE pulse. TONE=0, VOL=0, BUSY=0 afterwards, NOTE_STB pulsed once.
2. ROM[0]={5,15,1}, ROM[1]={0,15,1}, ROM[2]=end, LOOP=1 → TONE 5 then 0. After the end marker, ROM_ADDR returns to 0, NOTE_STB pulses again, DONE never pulses.
3. With NOTE_GAP_EN and entries {10,8,1},{20,8,1},end → after the 4 PLAY cycles of tone 10, VOL=0 for 2 cycles with TONE=10, then 2 FETCH/LOAD cycles, then TONE=20, VOL=8.
4. STOP mid-PLAY of a dur=3 note → next cycle TONE=0, VOL=0, BUSY=0, no DONE. A START in the same cycle as STOP while IDLE is ignored.
5. START_ADDR=15 with ROM[15]={48,4,1}, ROM[0]={49,4,1}, ROM[1]=end → TONE=48, ROM_ADDR wraps to 0, then TONE=0 with VOL=4 (out-of-range tone clamped), then DONE.
6. Assert RST_N=0 mid-PLAY for one cycle → all outputs 0 and state IDLE on the next cycle. A START pulse after reset replays from START_ADDR.
